// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_sequencer
// Description : Multi-cycle instruction sequencer. Latches an instruction
//               while idle and steps the datapath strobes through each phase.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] instr,
    output logic        w,
    output logic        illegal,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        write,
    output logic        asel,
    output logic        bsel,
    output logic        vsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic [15:0] datapath_in,
    output logic [7:0]  instr_count
);

    typedef enum logic [2:0] {
        WAIT      = 3'd0,
        GET_A     = 3'd1,
        GET_B     = 3'd2,
        EXEC      = 3'd3,
        WRITE_REG = 3'd4,
        WRITE_IMM = 3'd5,
        ILLEGAL   = 3'd6
    } state_t;

    // {opcode, op} pairs
    localparam logic [4:0] c_MOV_IMM = 5'b110_10;
    localparam logic [4:0] c_MOV_REG = 5'b110_00;
    localparam logic [4:0] c_ADD     = 5'b101_00;
    localparam logic [4:0] c_CMP     = 5'b101_01;
    localparam logic [4:0] c_AND     = 5'b101_10;
    localparam logic [4:0] c_MVN     = 5'b101_11;

    state_t      r_state;
    state_t      w_next_state;
    logic [15:0] r_ir;
    logic [7:0]  r_instr_count;
    logic [4:0]  w_ir_class;
    logic        w_ir_alu;

    assign w_ir_class = r_ir[15:11];
    assign w_ir_alu   = (r_ir[15:13] == 3'b101);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= WAIT;
            r_ir          <= 16'h0000;
            r_instr_count <= 8'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == WAIT && s) begin
                r_ir <= instr;
            end
            // Completed legal instructions are counted as they return to idle
            if (w_next_state == WAIT && r_state != WAIT && r_state != ILLEGAL) begin
                r_instr_count <= r_instr_count + 8'd1;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            WAIT: begin
                if (s) begin
                    case (instr[15:11])
                        c_MOV_IMM:             w_next_state = WRITE_IMM;
                        c_MOV_REG, c_MVN:      w_next_state = GET_B;
                        c_ADD, c_CMP, c_AND:   w_next_state = GET_A;
                        default:               w_next_state = ILLEGAL;
                    endcase
                end
            end
            GET_A:     w_next_state = GET_B;
            GET_B:     w_next_state = EXEC;
            EXEC:      w_next_state = (w_ir_class == c_CMP) ? WAIT : WRITE_REG;
            WRITE_REG: w_next_state = WAIT;
            WRITE_IMM: w_next_state = WAIT;
            ILLEGAL:   w_next_state = WAIT;
            default:   w_next_state = WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        illegal  = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        write    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = 1'b0;
        shift    = 2'd0;
        ALUop    = 2'd0;
        case (r_state)
            WAIT:    w       = 1'b1;
            ILLEGAL: illegal = 1'b1;
            GET_A: begin
                readnum = r_ir[10:8];
                loada   = 1'b1;
            end
            GET_B: begin
                readnum = r_ir[2:0];
                loadb   = 1'b1;
            end
            EXEC: begin
                shift = r_ir[4:3];
                bsel  = 1'b0;
                // MOV reg passes B through an ADD with A forced to zero
                if (w_ir_alu) begin
                    ALUop = r_ir[12:11];
                    asel  = (w_ir_class == c_MVN);
                end else begin
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end
                if (w_ir_class == c_CMP) begin
                    loads = 1'b1;
                end else begin
                    loadc = 1'b1;
                end
            end
            WRITE_REG: begin
                write    = 1'b1;
                writenum = r_ir[7:5];
                vsel     = 1'b0;
            end
            WRITE_IMM: begin
                write    = 1'b1;
                writenum = r_ir[10:8];
                vsel     = 1'b1;
            end
            default: begin
                w = 1'b0;
            end
        endcase
    end

    assign datapath_in = {{8{r_ir[7]}}, r_ir[7:0]};
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_sequencer
// Description : Self-checking bench for instr_sequencer against a step-list model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_sequencer;

    logic        clk;
    logic        reset;
    logic        s;
    logic [15:0] instr;
    logic        w, illegal;
    logic [2:0]  readnum, writenum;
    logic        loada, loadb, loadc, loads, write;
    logic        asel, bsel, vsel;
    logic [1:0]  shift, ALUop;
    logic [15:0] datapath_in;
    logic [7:0]  instr_count;

    int checks   = 0;
    int failures = 0;
    logic comp_en = 1'b0;

    instr_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .s           (s),
        .instr       (instr),
        .w           (w),
        .illegal     (illegal),
        .readnum     (readnum),
        .writenum    (writenum),
        .loada       (loada),
        .loadb       (loadb),
        .loadc       (loadc),
        .loads       (loads),
        .write       (write),
        .asel        (asel),
        .bsel        (bsel),
        .vsel        (vsel),
        .shift       (shift),
        .ALUop       (ALUop),
        .datapath_in (datapath_in),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per busy cycle of an instruction; last marks a counted completion
    typedef struct packed {
        logic       illegal;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       write;
        logic       asel;
        logic       bsel;
        logic       vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
        logic       last;
    } ctl_t;

    ctl_t        mq[$];
    logic [7:0]  m_count;
    logic [15:0] m_ir;

    task automatic enqueue(input logic [15:0] i);
        ctl_t z, ga, gb, ex, wr;
        z = '0;
        ga = z; ga.readnum = i[10:8]; ga.loada = 1'b1;
        gb = z; gb.readnum = i[2:0];  gb.loadb = 1'b1;
        ex = z; ex.shift = i[4:3];    ex.loadc = 1'b1;
        wr = z; wr.write = 1'b1;      wr.writenum = i[7:5]; wr.last = 1'b1;
        case (i[15:11])
            5'b110_10: begin
                wr.writenum = i[10:8];
                wr.vsel     = 1'b1;
                mq.push_back(wr);
            end
            5'b110_00: begin
                ex.asel = 1'b1;
                mq.push_back(gb); mq.push_back(ex); mq.push_back(wr);
            end
            5'b101_00, 5'b101_10: begin
                ex.aluop = i[12:11];
                mq.push_back(ga); mq.push_back(gb); mq.push_back(ex); mq.push_back(wr);
            end
            5'b101_01: begin
                ex.aluop = 2'b01; ex.loadc = 1'b0; ex.loads = 1'b1; ex.last = 1'b1;
                mq.push_back(ga); mq.push_back(gb); mq.push_back(ex);
            end
            5'b101_11: begin
                ex.aluop = 2'b11; ex.asel = 1'b1;
                mq.push_back(gb); mq.push_back(ex); mq.push_back(wr);
            end
            default: begin
                z.illegal = 1'b1;
                mq.push_back(z);
            end
        endcase
    endtask

    always @(posedge clk) begin
        ctl_t st;
        if (reset) begin
            mq.delete();
            m_count = 8'd0;
            m_ir    = 16'h0000;
        end else if (mq.size() != 0) begin
            st = mq.pop_front();
            if (st.last) m_count = m_count + 8'd1;
        end else if (s) begin
            m_ir = instr;
            enqueue(instr);
        end
    end

    function automatic logic [43:0] model_out();
        ctl_t c;
        logic wexp;
        c = '0;
        wexp = 1'b1;
        if (mq.size() != 0) begin
            c = mq[0];
            wexp = 1'b0;
        end
        return {wexp, c.illegal, c.readnum, c.writenum, c.loada, c.loadb, c.loadc,
                c.loads, c.write, c.asel, c.bsel, c.vsel, c.shift, c.aluop,
                {{8{m_ir[7]}}, m_ir[7:0]}, m_count};
    endfunction

    logic [43:0] dut_out;
    assign dut_out = {w, illegal, readnum, writenum, loada, loadb, loadc, loads, write,
                      asel, bsel, vsel, shift, ALUop, datapath_in, instr_count};

    always @(negedge clk) begin
        logic [43:0] e;
        if (comp_en) begin
            e = model_out();
            checks++;
            if (dut_out !== e) begin
                failures++;
                $display("FAIL cycle_compare t=%0t actual=%h required=%h", $time, dut_out, e);
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input int n);
        int k;
        k = 0;
        while (w !== 1'b1 && k < n) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL wait_idle_timeout actual=%b required=1", w);
        end
    endtask

    task automatic run_instr(input logic [15:0] i);
        s = 1'b1;
        instr = i;
        @(negedge clk);
        s = 1'b0;
        wait_idle(8);
    endtask

    initial begin
        reset = 1'b1;
        s     = 1'b0;
        instr = 16'h0000;
        @(negedge clk);
        comp_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst_w", 16'(w), 16'd1);
        chk("rst_illegal", 16'(illegal), 16'd0);
        chk("rst_strobes", 16'({loada, loadb, loadc, loads, write, asel, bsel, vsel}), 16'd0);
        chk("rst_dp_in", datapath_in, 16'h0000);
        chk("rst_count", 16'(instr_count), 16'd0);

        // MOV R3,#-5
        s = 1'b1; instr = 16'hD3FB;
        @(negedge clk);
        s = 1'b0;
        chk("movi_write", 16'(write), 16'd1);
        chk("movi_writenum", 16'(writenum), 16'd3);
        chk("movi_vsel", 16'(vsel), 16'd1);
        chk("movi_dp_in", datapath_in, 16'hFFFB);
        @(negedge clk);
        chk("movi_w", 16'(w), 16'd1);
        chk("movi_count", 16'(instr_count), 16'd1);

        // ADD R2,R1,R0 LSL#1
        s = 1'b1; instr = 16'hA148;
        @(negedge clk);
        s = 1'b0;
        chk("add_c1_readnum", 16'(readnum), 16'd1);
        chk("add_c1_loada", 16'(loada), 16'd1);
        @(negedge clk);
        chk("add_c2_readnum", 16'(readnum), 16'd0);
        chk("add_c2_loadb", 16'(loadb), 16'd1);
        @(negedge clk);
        chk("add_c3_loadc", 16'(loadc), 16'd1);
        chk("add_c3_shift", 16'(shift), 16'd1);
        chk("add_c3_aluop", 16'(ALUop), 16'd0);
        chk("add_c3_asel_bsel", 16'({asel, bsel}), 16'd0);
        @(negedge clk);
        chk("add_c4_write", 16'(write), 16'd1);
        chk("add_c4_writenum", 16'(writenum), 16'd2);
        chk("add_c4_vsel", 16'(vsel), 16'd0);
        @(negedge clk);
        chk("add_c5_w", 16'(w), 16'd1);
        chk("add_count", 16'(instr_count), 16'd2);

        // CMP R1,R2
        s = 1'b1; instr = 16'hA902;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            s = 1'b0;
            chk("cmp_no_write", 16'(write), 16'd0);
            if (c == 3) begin
                chk("cmp_loads", 16'(loads), 16'd1);
                chk("cmp_loadc", 16'(loadc), 16'd0);
            end
        end
        chk("cmp_w", 16'(w), 16'd1);
        chk("cmp_count", 16'(instr_count), 16'd3);

        // Undecodable instruction
        s = 1'b1; instr = 16'h0000;
        @(negedge clk);
        s = 1'b0;
        chk("ill_pulse", 16'(illegal), 16'd1);
        chk("ill_strobes", 16'({loada, loadb, loadc, loads, write}), 16'd0);
        chk("ill_w", 16'(w), 16'd0);
        @(negedge clk);
        chk("ill_end", 16'(illegal), 16'd0);
        chk("ill_w_back", 16'(w), 16'd1);
        chk("ill_count", 16'(instr_count), 16'd3);

        // Back-to-back MVN, MOV reg, AND
        run_instr(16'hB8A3);
        run_instr(16'hC0F2);
        run_instr(16'hB26A);
        chk("b2b_count", 16'(instr_count), 16'd6);

        // Reset during GET_B of ADD
        s = 1'b1; instr = 16'hA148;
        @(negedge clk);
        s = 1'b0;
        @(negedge clk);
        chk("rstmid_in_getb", 16'(loadb), 16'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_w", 16'(w), 16'd1);
        chk("rstmid_write", 16'(write), 16'd0);
        chk("rstmid_count", 16'(instr_count), 16'd0);
        @(negedge clk);
        chk("rstmid_write_after", 16'(write), 16'd0);
        chk("rstmid_w_after", 16'(w), 16'd1);

        // 256 MOV imm with s held high, including busy cycles
        s = 1'b1;
        for (int i = 0; i < 256; i++) begin
            instr = {5'b11010, 3'(i), 8'(i)};
            @(negedge clk);
            instr = 16'h0000;
            @(negedge clk);
            if (i == 254) chk("wrap_count_255", 16'(instr_count), 16'd255);
        end
        s = 1'b0;
        chk("wrap_count_0", 16'(instr_count), 16'd0);
        chk("wrap_w", 16'(w), 16'd1);
        @(negedge clk);
        chk("wrap_idle_illegal", 16'(illegal), 16'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
